// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, baud counter and serialiser FSM.
// Optional feature: define UART_PARITY_EN to add an even/odd parity bit (CTRL[3:2]).
module uart_tx_periph #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned DIV_RESET  = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        wr_en,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e               state_q, state_d;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [CntW-1:0]      count_q;
  logic                 enable_q, overflow_q;
  logic [DIV_WIDTH-1:0] div_q, cur_div_q, baud_q;
  logic [2:0]           idx_q;
  logic [7:0]           shift_q;
  logic                 tx_q, tx_d, last_level;
  logic                 busy, pop, bit_end, fifo_empty, fifo_full;
  logic                 wr, wr_ctrl, wr_stat, wr_txd, wr_div, flush, push_ok;
  logic                 unused_bits;
`ifdef UART_PARITY_EN
  logic                 par_en_cfg_q, par_odd_cfg_q, par_en_q, par_bit_q;
`endif

  assign wr         = ce && wr_en;
  assign wr_ctrl    = wr && (addr[3:2] == 2'd0);
  assign wr_stat    = wr && (addr[3:2] == 2'd1);
  assign wr_txd     = wr && (addr[3:2] == 2'd2);
  assign wr_div     = wr && (addr[3:2] == 2'd3);
  assign flush      = wr_ctrl && wdata[1];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = wr_txd && !flush && (!fifo_full || pop);
  assign bit_end    = (state_q != StIdle) && (baud_q == cur_div_q - DIV_WIDTH'(1));
  assign tx         = tx_q;
  assign unused_bits = ^{addr[1:0], wdata};

`ifdef UART_PARITY_EN
  assign last_level = par_en_q ? par_bit_q : 1'b1;
`else
  assign last_level = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable_q && !fifo_empty) begin
          state_d = StStart;
          pop     = 1'b1;
        end
      end
      StStart: if (bit_end) state_d = StData;
      StData: begin
        if (bit_end && (idx_q == 3'd7)) begin
`ifdef UART_PARITY_EN
          state_d = par_en_q ? StParity : StStop;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef UART_PARITY_EN
      StParity: if (bit_end) state_d = StStop;
`endif
      StStop: begin
        if (bit_end) begin
          if (enable_q && !fifo_empty) begin
            state_d = StStart;
            pop     = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    tx_d = tx_q;
    if (pop) begin
      tx_d = 1'b0;
    end else if (bit_end) begin
      case (state_q)
        StStart: tx_d = shift_q[0];
        StData:  tx_d = (idx_q == 3'd7) ? last_level : shift_q[idx_q + 3'd1];
        default: tx_d = 1'b1;
      endcase
    end
  end

  // Serialiser datapath; cur_div_q latches DIV per bit so writes land on a boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q      <= 1'b1;
      baud_q    <= '0;
      cur_div_q <= DIV_WIDTH'(DIV_RESET);
      idx_q     <= '0;
      shift_q   <= '0;
`ifdef UART_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      tx_q <= tx_d;
      if (pop || bit_end) begin
        baud_q    <= '0;
        cur_div_q <= div_q;
      end else if (busy) begin
        baud_q <= baud_q + DIV_WIDTH'(1);
      end
      if (pop) begin
        idx_q     <= '0;
        shift_q   <= mem_q[rptr_q];
`ifdef UART_PARITY_EN
        par_en_q  <= par_en_cfg_q;
        par_bit_q <= (^mem_q[rptr_q]) ^ par_odd_cfg_q;
`endif
      end else if (bit_end && (state_q == StData)) begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop)     rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_ok) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q      <= 1'b0;
      overflow_q    <= 1'b0;
      div_q         <= DIV_WIDTH'(DIV_RESET);
`ifdef UART_PARITY_EN
      par_en_cfg_q  <= 1'b0;
      par_odd_cfg_q <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) begin
        enable_q      <= wdata[0];
`ifdef UART_PARITY_EN
        par_en_cfg_q  <= wdata[2];
        par_odd_cfg_q <= wdata[3];
`endif
      end
      if (wr_div) begin
        div_q <= (wdata[DIV_WIDTH-1:0] == '0) ? DIV_WIDTH'(1) : wdata[DIV_WIDTH-1:0];
      end
      if (wr_txd && !flush && fifo_full && !pop) overflow_q <= 1'b1;
      else if (wr_stat && wdata[3])               overflow_q <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      2'd0: begin
        rdata[0] = enable_q;
`ifdef UART_PARITY_EN
        rdata[3:2] = {par_odd_cfg_q, par_en_cfg_q};
`endif
      end
      2'd1:    rdata[8:0] = {5'(count_q), overflow_q, fifo_empty, fifo_full, busy};
      2'd2:    rdata = '0;
      default: rdata[DIV_WIDTH-1:0] = div_q;
    endcase
  end
endmodule
